// File: rtl/md_pkg.sv
// Shared definitions for the MiniSys-1A iterative multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    localparam int unsigned MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_negate.sv
// Combinational two's-complement negate, shared by the abs and sign-fix stages.
module md_negate #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = '0 - x;

endmodule

// File: rtl/md_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic [4:0]         cnt;
    logic [1:0]         op_r;
    logic               sign_r;
    logic               rsign_r;
    logic               dz_r;
    logic [WIDTH-1:0]   opd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [WIDTH-1:0]   neg_a, neg_b, abs_a, abs_b;
    logic [2*WIDTH-1:0] neg_prod, prod;
    logic [WIDTH-1:0]   neg_quo, neg_rem, fix_quo, fix_rem;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   res_hi, res_lo;

    md_negate #(.W(WIDTH))   u_neg_a    (.x(a),   .y(neg_a));
    md_negate #(.W(WIDTH))   u_neg_b    (.x(b),   .y(neg_b));
    md_negate #(.W(2*WIDTH)) u_neg_prod (.x(acc), .y(neg_prod));
    md_negate #(.W(WIDTH))   u_neg_quo  (.x(quo), .y(neg_quo));
    md_negate #(.W(WIDTH))   u_neg_rem  (.x(rem), .y(neg_rem));

    always_comb begin
        abs_a = (op[0] && a[WIDTH-1]) ? neg_a : a;
        abs_b = (op[0] && b[WIDTH-1]) ? neg_b : b;

        // Multiply: acc[63:32] accumulates, acc[31:0] shifts out the multiplier.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd};
        // Divide: 33-bit trial remainder formed from rem and the next dividend bit.
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opd};

        prod    = (op_r[0] && sign_r) ? neg_prod : acc;
        fix_quo = sign_r  ? neg_quo : quo;
        fix_rem = rsign_r ? neg_rem : rem;

        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (op_r[1]) begin
            // Divide-by-zero leaves rem equal to |a|, so the sign fix restores a.
            res_hi = fix_rem;
            res_lo = dz_r ? '1 : fix_quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= '0;
            sign_r   <= 1'b0;
            rsign_r  <= 1'b0;
            dz_r     <= 1'b0;
            opd      <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we || lo_we) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end else if (start && !flush) begin
                        state   <= CALC;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        op_r    <= op;
                        sign_r  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rsign_r <= op[0] & a[WIDTH-1];
                        dz_r    <= op[1] && (b == '0);
                        opd     <= op[1] ? abs_b : abs_a;
                        acc     <= {{WIDTH{1'b0}}, abs_b};
                        quo     <= abs_a;
                        rem     <= '0;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (!op_r[1]) begin
                            if (acc[0]) acc <= {mul_sum, acc[WIDTH-1:1]};
                            else        acc <= {1'b0, acc[2*WIDTH-1:1]};
                        end else if (!div_diff[WIDTH]) begin
                            rem <= div_diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= div_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MD_ITER - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi       <= res_hi;
                        lo       <= res_lo;
                        done     <= 1'b1;
                        div_zero <= dz_r;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
